// File: rtl/pixel_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_writer_pkg                                                |
// | Purpose  : Shared types and helpers for the pixel writer stage.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pixel_writer_pkg;

    // Queue entry fields are sized for the largest supported frame and colour depth.
    localparam int c_pw_addr_max  = 24;
    localparam int c_pw_color_max = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } pw_state_t;

    typedef struct packed {
        logic [c_pw_addr_max-1:0]  addr;
        logic [c_pw_color_max-1:0] color;
    } pix_entry_t;

    function automatic int calc_addr_width(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_fifo                                                      |
// | Purpose  : Synchronous FIFO with registered storage and show-ahead head.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_writer                                                    |
// | Purpose  : Clips rasteriser pixels, queues them and writes the framebuffer;|
// |            also performs a full-frame clear sweep.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180,
    parameter int COLOR_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = calc_addr_width(FB_WIDTH, FB_HEIGHT)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pix_valid,
    input  logic signed [COORD_WIDTH-1:0] pix_x,
    input  logic signed [COORD_WIDTH-1:0] pix_y,
    input  logic        [COLOR_WIDTH-1:0] pix_color,
    output logic                          pix_ready,
    input  logic                          clear_start,
    input  logic        [COLOR_WIDTH-1:0] clear_color,
    input  logic                          fb_stall,
    output logic                          fb_we,
    output logic        [ADDR_WIDTH-1:0]  fb_addr,
    output logic        [COLOR_WIDTH-1:0] fb_data,
    output logic                          busy,
    output logic                          clear_done,
    output logic        [15:0]            clipped_count
);

    localparam int c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam int c_fb_pixels = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_fb_pixels - 1);

    pw_state_t              r_state;
    pw_state_t              w_state_next;
    logic [ADDR_WIDTH-1:0]  r_sweep;
    logic [COLOR_WIDTH-1:0] r_clear_color;
    logic                   r_fb_we;
    logic [ADDR_WIDTH-1:0]  r_fb_addr;
    logic [COLOR_WIDTH-1:0] r_fb_data;
    logic                   r_clear_done;
    logic [15:0]            r_clipped;

    logic signed [31:0]     w_x_s;
    logic signed [31:0]     w_y_s;
    logic                   w_in_bounds;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_sweep_wr;
    pix_entry_t             w_push_entry;
    pix_entry_t             w_head;
    logic [c_cnt_w-1:0]     w_count;
    logic                   w_empty;
    logic                   w_fifo_full;
    logic                   w_unused;

    assign w_x_s       = 32'(pix_x);
    assign w_y_s       = 32'(pix_y);
    assign w_in_bounds = (w_x_s >= 0) && (w_x_s < FB_WIDTH) &&
                         (w_y_s >= 0) && (w_y_s < FB_HEIGHT);

    assign pix_ready  = (r_state == ST_IDLE) && (w_count < c_cnt_w'(FIFO_DEPTH));
    assign w_accept   = pix_valid && pix_ready;
    assign w_push     = w_accept && w_in_bounds;
    assign w_pop      = !w_empty && !fb_stall && (r_state != ST_CLEAR);
    assign w_sweep_wr = (r_state == ST_CLEAR) && !fb_stall;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.addr  = c_pw_addr_max'(w_y_s * FB_WIDTH + w_x_s);
        w_push_entry.color = c_pw_color_max'(pix_color);
    end

    pixel_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_push_entry),
        .dout   (w_head),
        .count  (w_count),
        .empty  (w_empty),
        .full   (w_fifo_full)
    );

    // Entry padding bits above ADDR_WIDTH/COLOR_WIDTH are never needed downstream.
    assign w_unused = ^{w_head.addr, w_head.color, w_fifo_full};

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (clear_start) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_empty)     w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_sweep_wr && (r_sweep == c_last_addr)) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sweep       <= '0;
            r_clear_color <= '0;
            r_fb_we       <= 1'b0;
            r_fb_addr     <= '0;
            r_fb_data     <= '0;
            r_clear_done  <= 1'b0;
            r_clipped     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && clear_start) r_clear_color <= clear_color;

            if (r_state == ST_DRAIN)  r_sweep <= '0;
            else if (w_sweep_wr)      r_sweep <= r_sweep + ADDR_WIDTH'(1);

            r_fb_we <= w_pop || w_sweep_wr;
            if (w_sweep_wr) begin
                r_fb_addr <= r_sweep;
                r_fb_data <= r_clear_color;
            end else if (w_pop) begin
                r_fb_addr <= w_head.addr[ADDR_WIDTH-1:0];
                r_fb_data <= w_head.color[COLOR_WIDTH-1:0];
            end

            r_clear_done <= w_sweep_wr && (r_sweep == c_last_addr);

            if (w_accept && !w_in_bounds && (r_clipped != 16'hFFFF))
                r_clipped <= r_clipped + 16'd1;
        end
    end

    assign fb_we         = r_fb_we;
    assign fb_addr       = r_fb_addr;
    assign fb_data       = r_fb_data;
    assign clear_done    = r_clear_done;
    assign clipped_count = r_clipped;
    assign busy          = (r_state != ST_IDLE) || !w_empty || r_fb_we;

endmodule
`default_nettype wire

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
Downstream stage of the Bresenham line rasteriser. It accepts one pixel per cycle as (x, y, colour), and its pix_ready output drives the rasteriser's oe pause input. It clips each pixel to the framebuffer, converts it to a linear address and buffers it in a small FIFO. It then issues single-cycle writes to the framebuffer BRAM port, and also provides a full-frame clear sweep.

Parameters:
COORD_WIDTH, 16, width of signed pixel coordinates
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 180, framebuffer height in pixels
COLOR_WIDTH, 8, pixel data width
FIFO_DEPTH, 4, pixel buffer entries (power of two, >=2)
ADDR_WIDTH, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width (16 at defaults)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-high
pix_valid  input  1  pixel present (rasteriser drawing output)
pix_x  input  COORD_WIDTH signed  pixel x
pix_y  input  COORD_WIDTH signed  pixel y
pix_color  input  COLOR_WIDTH  pixel colour
pix_ready  output  1  combinational; drives rasteriser oe
clear_start  input  1  one-cycle request to fill the frame
clear_color  input  COLOR_WIDTH  fill colour, sampled with clear_start
fb_stall  input  1  framebuffer port unavailable this cycle
fb_we  output  1  registered write enable
fb_addr  output  ADDR_WIDTH  registered write address
fb_data  output  COLOR_WIDTH  registered write data
busy  output  1  work pending
clear_done  output  1  one-cycle pulse at end of clear
clipped_count  output  16  saturating count of discarded pixels

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0, clear_done=0, clipped_count=0.
  - FIFO empty, state IDLE; busy=0 from the cycle after reset.
- Reset mid-operation (including mid-clear): all queued pixels are discarded, the sweep is abandoned, no clear_done pulse is emitted.
- States: IDLE, DRAIN, CLEAR.
- pix_ready = (state==IDLE) && (count < FIFO_DEPTH). It is purely combinational from registers and never depends on pix_valid.
- Accept: pix_valid && pix_ready in a cycle.
  - In-bounds means 0<=x<FB_WIDTH and 0<=y<FB_HEIGHT (signed compare).
  - In-bounds pixel: push {y*FB_WIDTH+x, colour}. The product is computed at full width, then truncated to ADDR_WIDTH.
  - Out-of-bounds pixel: the handshake still completes, nothing is pushed, and clipped_count increments, saturating at 0xFFFF.
- Pop: FIFO non-empty && !fb_stall && state!=CLEAR. The next cycle gives fb_we=1 with the head's addr/data. Otherwise fb_we=0; fb_addr/fb_data hold their last values.
- Simultaneous push and pop is allowed, including at count==FIFO_DEPTH-1 and count==FIFO_DEPTH (pop only); count adjusts by the net change.
- Write order equals acceptance order.
- Latency: pixel accepted in cycle N gives fb_we in cycle N+2 at the earliest (FIFO write N, pop N+1, registered output N+2).
- clear_start in IDLE:
  - Latch clear_color and go to DRAIN; pix_ready drops next cycle.
  - clear_start outside IDLE is ignored.
- DRAIN: keep popping normally. When the FIFO is empty, go to CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle with !fb_stall, write counter/latched colour (registered, fb_we next cycle) and increment the counter.
  - After writing address FB_WIDTH*FB_HEIGHT-1, go to IDLE and pulse clear_done for exactly one cycle, coincident with the final fb_we.
  - fb_stall freezes the counter; no address is skipped or repeated.
- busy = (state!=IDLE) || FIFO non-empty || fb_we.
- Simultaneous clear_start and an accepted pixel in the same IDLE cycle: the pixel is queued and written during DRAIN, before the sweep.

Decomposition:
- Package pixel_writer_pkg holds:
  - typedef pw_state_t (IDLE/DRAIN/CLEAR);
  - packed struct pix_entry_t {addr, color};
  - a function computing ADDR_WIDTH from the frame dimensions.
- One sub-module, pixel_fifo: synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, din, dout, count, empty, full.
  - Registered storage, show-ahead head.

Test Plan:
- Single pixel (10,5), colour 0x3C, accepted cycle N -> exactly one fb_we at cycle N+2 with addr 1610, data 0x3C; busy low afterwards.
- Corners (0,0), (319,179) -> writes to addr 0 and 57599 in order. Pixels (-1,0), (320,0), (0,180), (5,-3) -> no writes, clipped_count=4, pix_ready stays high.
- fb_stall held high, 4 pixels offered -> pix_ready low after the 4th accept and the 5th is held. Release stall -> 4 writes in order on consecutive cycles, then the 5th is accepted.
- With FB_WIDTH=8, FB_HEIGHT=4: clear_start with colour 0x55 while 2 pixels are queued:
  - the 2 pixels are written first;
  - then 32 writes, addr 0..31, data 0x55;
  - clear_done pulses once with the addr-31 write;
  - pix_ready is low from the cycle after clear_start until IDLE.
- During that clear, toggle fb_stall every other cycle -> each address 0..31 is written exactly once, in order.
- rst_in asserted mid-clear and with a full FIFO -> fb_we=0 next cycle, no clear_done pulse, busy=0, clipped_count=0, pix_ready=1.
